// File: rtl/rob_pkg.sv
// Shared defaults and the per-entry payload record of the N-wide reorder buffer.
package rob_pkg;

    localparam int ROB_SZ_DEF  = 32;
    localparam int WIDTH_DEF   = 2;
    localparam int CPL_DEF     = 3;
    localparam int PRF_IDX_DEF = 6;
    localparam int ARF_IDX_DEF = 5;
    localparam int ROB_IDX_DEF = $clog2(ROB_SZ_DEF);

    // Fields written once at allocation; completion status lives in separate arrays.
    typedef struct packed {
        logic [63:0]            npc;
        logic [31:0]            ir;
        logic [PRF_IDX_DEF-1:0] pdest;
        logic [ARF_IDX_DEF-1:0] adest;
        logic                   isbr;
        logic                   bt_pd;
        logic [63:0]            ba_pd;
    } rob_entry_t;

endpackage

// File: rtl/rob_nway_if.sv
// Allocation, completion, retirement and status bundle of the reorder buffer.
interface rob_nway_if
    import rob_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CPL     = CPL_DEF,
    parameter int ROB_IDX = ROB_IDX_DEF,
    parameter int PRF_IDX = PRF_IDX_DEF,
    parameter int ARF_IDX = ARF_IDX_DEF
);

    logic [WIDTH-1:0]                din_req;
    logic [WIDTH-1:0][63:0]          din_npc;
    logic [WIDTH-1:0][31:0]          din_ir;
    logic [WIDTH-1:0][PRF_IDX-1:0]   din_pdest;
    logic [WIDTH-1:0][ARF_IDX-1:0]   din_adest;
    logic [WIDTH-1:0]                din_isbr;
    logic [WIDTH-1:0]                din_bt_pd;
    logic [WIDTH-1:0][63:0]          din_ba_pd;
    logic [WIDTH-1:0]                din_gnt;
    logic [WIDTH-1:0][ROB_IDX-1:0]   rob_idx_out;

    logic [CPL-1:0]                  dup_req;
    logic [CPL-1:0][ROB_IDX-1:0]     dup_idx;
    logic [CPL-1:0]                  dup_bt;
    logic [CPL-1:0][63:0]            dup_ba;
    logic [CPL-1:0]                  dup_exc;

    logic [WIDTH-1:0]                dout_valid;
    logic [WIDTH-1:0][63:0]          dout_npc;
    logic [WIDTH-1:0][31:0]          dout_ir;
    logic [WIDTH-1:0][PRF_IDX-1:0]   dout_pdest;
    logic [WIDTH-1:0][ARF_IDX-1:0]   dout_adest;
    logic [WIDTH-1:0]                br_out_valid;
    logic [WIDTH-1:0]                bt_out;
    logic [WIDTH-1:0][63:0]          ba_out;

    logic                            branch_miss;
    logic [63:0]                     correct_target;
    logic                            exception;
    logic [63:0]                     exc_npc;
    logic                            flush;
    logic [ROB_IDX-1:0]              head;
    logic [ROB_IDX:0]                count;
    logic                            full;
    logic                            empty;

    modport master (
        output din_req, din_npc, din_ir, din_pdest, din_adest, din_isbr, din_bt_pd, din_ba_pd,
        output dup_req, dup_idx, dup_bt, dup_ba, dup_exc, flush,
        input  din_gnt, rob_idx_out,
        input  dout_valid, dout_npc, dout_ir, dout_pdest, dout_adest, br_out_valid, bt_out, ba_out,
        input  branch_miss, correct_target, exception, exc_npc, head, count, full, empty
    );

    modport slave (
        input  din_req, din_npc, din_ir, din_pdest, din_adest, din_isbr, din_bt_pd, din_ba_pd,
        input  dup_req, dup_idx, dup_bt, dup_ba, dup_exc, flush,
        output din_gnt, rob_idx_out,
        output dout_valid, dout_npc, dout_ir, dout_pdest, dout_adest, br_out_valid, bt_out, ba_out,
        output branch_miss, correct_target, exception, exc_npc, head, count, full, empty
    );

endinterface

// File: rtl/rob_retire_sel.sv
// In-order retire selection across WIDTH head slots: stops at the first
// not-ready slot, before an excepting slot, or just after a mispredicted branch.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]  rdy,
    input  logic [WIDTH-1:0]  miss,
    input  logic [WIDTH-1:0]  exc,
    output logic [WIDTH-1:0]  ret_mask,
    output logic              miss_hit,
    output logic              exc_hit,
    output logic [SLOT_W-1:0] rec_slot
);

    logic go;

    always_comb begin
        ret_mask = '0;
        miss_hit = 1'b0;
        exc_hit  = 1'b0;
        rec_slot = '0;
        go       = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (go && rdy[i]) begin
                if (exc[i]) begin
                    exc_hit  = 1'b1;
                    rec_slot = SLOT_W'(i);
                    go       = 1'b0;
                end else begin
                    ret_mask[i] = 1'b1;
                    if (miss[i]) begin
                        miss_hit = 1'b1;
                        rec_slot = SLOT_W'(i);
                        go       = 1'b0;
                    end
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: WIDTH allocations and retirements per cycle, CPL completion
// ports, branch-mispredict / exception recovery that empties the buffer.
module rob_nway
    import rob_pkg::*;
#(
    parameter int ROB_SZ  = ROB_SZ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CPL     = CPL_DEF,
    parameter int PRF_IDX = PRF_IDX_DEF,
    parameter int ARF_IDX = ARF_IDX_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    rob_nway_if.slave   bus
);

    localparam int ROB_IDX = $clog2(ROB_SZ);
    localparam int PTR_W   = ROB_IDX + 1;
    localparam int SLOT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PTR_W-1:0]  head_reg, tail_reg, head_next, tail_next, count_w;
    logic [PTR_W-1:0]  n_ret, n_gnt;
    logic [ROB_SZ-1:0] ready_reg, exc_reg, bt_ex_reg;
    logic [63:0]       ba_ex_reg [ROB_SZ];
    rob_entry_t        mem [ROB_SZ];

    logic [WIDTH-1:0][ROB_IDX-1:0] slot_idx, alloc_idx;
    logic [WIDTH-1:0]              slot_rdy, slot_miss, slot_exc, ret_mask, gnt;
    rob_entry_t                    new_entry [WIDTH];
    logic [CPL-1:0][ROB_IDX-1:0]   dup_off;
    logic [CPL-1:0]                dup_ok;
    logic                          miss_hit, exc_hit, recover;
    logic [SLOT_W-1:0]             rec_slot;

    assign count_w = tail_reg - head_reg;
    assign recover = miss_hit | exc_hit | bus.flush;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
            assign slot_idx[gi]  = head_reg[ROB_IDX-1:0] + ROB_IDX'(gi);
            assign alloc_idx[gi] = tail_reg[ROB_IDX-1:0] + ROB_IDX'(gi);
            assign slot_rdy[gi]  = (count_w > PTR_W'(gi)) && ready_reg[slot_idx[gi]];
            assign slot_exc[gi]  = exc_reg[slot_idx[gi]];
            assign slot_miss[gi] = mem[slot_idx[gi]].isbr &&
                                   ((bt_ex_reg[slot_idx[gi]] != mem[slot_idx[gi]].bt_pd) ||
                                    (bt_ex_reg[slot_idx[gi]] &&
                                     (ba_ex_reg[slot_idx[gi]] != mem[slot_idx[gi]].ba_pd)));
            // Grant depends only on occupancy at the start of the cycle, not on retirement.
            assign gnt[gi] = reset_n && !recover && bus.din_req[gi] &&
                             (PTR_W'(gi) < PTR_W'(ROB_SZ) - count_w);

            assign new_entry[gi] = '{npc:   bus.din_npc[gi],   ir:    bus.din_ir[gi],
                                     pdest: bus.din_pdest[gi], adest: bus.din_adest[gi],
                                     isbr:  bus.din_isbr[gi],  bt_pd: bus.din_bt_pd[gi],
                                     ba_pd: bus.din_ba_pd[gi]};

            assign bus.din_gnt[gi]      = gnt[gi];
            assign bus.rob_idx_out[gi]  = alloc_idx[gi];
            assign bus.dout_valid[gi]   = ret_mask[gi];
            assign bus.dout_npc[gi]     = mem[slot_idx[gi]].npc;
            assign bus.dout_ir[gi]      = mem[slot_idx[gi]].ir;
            assign bus.dout_pdest[gi]   = mem[slot_idx[gi]].pdest;
            assign bus.dout_adest[gi]   = mem[slot_idx[gi]].adest;
            assign bus.br_out_valid[gi] = ret_mask[gi] && mem[slot_idx[gi]].isbr;
            assign bus.bt_out[gi]       = bt_ex_reg[slot_idx[gi]];
            assign bus.ba_out[gi]       = ba_ex_reg[slot_idx[gi]];
        end

        // A completion is live only if its index lies between head and tail.
        for (genvar gi = 0; gi < CPL; gi++) begin : g_dup
            assign dup_off[gi] = bus.dup_idx[gi] - head_reg[ROB_IDX-1:0];
            assign dup_ok[gi]  = bus.dup_req[gi] && ({1'b0, dup_off[gi]} < count_w);
        end
    endgenerate

    rob_retire_sel #(.WIDTH(WIDTH), .SLOT_W(SLOT_W)) u_retire_sel (
        .rdy      (slot_rdy),
        .miss     (slot_miss),
        .exc      (slot_exc),
        .ret_mask (ret_mask),
        .miss_hit (miss_hit),
        .exc_hit  (exc_hit),
        .rec_slot (rec_slot)
    );

    assign bus.branch_miss    = miss_hit;
    assign bus.correct_target = miss_hit ? ba_ex_reg[slot_idx[rec_slot]] : 64'd0;
    assign bus.exception      = exc_hit;
    assign bus.exc_npc        = exc_hit ? mem[slot_idx[rec_slot]].npc : 64'd0;
    assign bus.head           = head_reg[ROB_IDX-1:0];
    assign bus.count          = count_w;
    assign bus.full           = (count_w == PTR_W'(ROB_SZ));
    assign bus.empty          = (count_w == '0);

    always_comb begin
        n_ret = '0;
        n_gnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_ret = n_ret + PTR_W'(ret_mask[i]);
            n_gnt = n_gnt + PTR_W'(gnt[i]);
        end
        head_next = head_reg + n_ret;
        tail_next = recover ? head_next : (tail_reg + n_gnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            ready_reg <= '0;
            exc_reg   <= '0;
            bt_ex_reg <= '0;
            for (int k = 0; k < ROB_SZ; k++) begin
                ba_ex_reg[k] <= '0;
            end
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            // Later ports overwrite earlier ones; allocation last so a reused slot starts clean.
            if (!recover) begin
                for (int p = 0; p < CPL; p++) begin
                    if (dup_ok[p]) begin
                        ready_reg[bus.dup_idx[p]] <= 1'b1;
                        exc_reg[bus.dup_idx[p]]   <= bus.dup_exc[p];
                        bt_ex_reg[bus.dup_idx[p]] <= bus.dup_bt[p];
                        ba_ex_reg[bus.dup_idx[p]] <= bus.dup_ba[p];
                    end
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (gnt[i]) begin
                    ready_reg[alloc_idx[i]] <= 1'b0;
                    exc_reg[alloc_idx[i]]   <= 1'b0;
                    bt_ex_reg[alloc_idx[i]] <= 1'b0;
                    ba_ex_reg[alloc_idx[i]] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt[i]) begin
                mem[alloc_idx[i]] <= new_entry[i];
            end
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed vector table, hand sequences for fill/recovery/reset,
// then randomized traffic against a queue-based reference model.
module tb_rob_nway;
    import rob_pkg::*;

    localparam int W  = 2;
    localparam int C  = 3;
    localparam int SZ = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rob_nway_if #(.WIDTH(W), .CPL(C), .ROB_IDX(IW), .PRF_IDX(6), .ARF_IDX(5)) bus ();

    rob_nway #(.ROB_SZ(SZ), .WIDTH(W), .CPL(C), .PRF_IDX(6), .ARF_IDX(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.din_req   = '0;
        bus.din_npc   = '0;
        bus.din_ir    = '0;
        bus.din_pdest = '0;
        bus.din_adest = '0;
        bus.din_isbr  = '0;
        bus.din_bt_pd = '0;
        bus.din_ba_pd = '0;
        bus.dup_req   = '0;
        bus.dup_idx   = '0;
        bus.dup_bt    = '0;
        bus.dup_ba    = '0;
        bus.dup_exc   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_dup(input int p, input int idx, input bit bt, input logic [63:0] ba, input bit exc);
        bus.dup_req[p] = 1'b1;
        bus.dup_idx[p] = IW'(idx);
        bus.dup_bt[p]  = bt;
        bus.dup_ba[p]  = ba;
        bus.dup_exc[p] = exc;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic [2:0] dreq;
        logic [2:0] dexc;
        logic [4:0] di0, di1, di2;
        logic [1:0] gnt;
        logic [1:0] dval;
        logic       exc;
        logic [5:0] cnt;
    } vec_t;

    vec_t tbl [9];

    task automatic run_table();
        tbl[0] = '{2'b11, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 2'b11, 2'b00, 1'b0, 6'd2};
        tbl[1] = '{2'b01, 3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 6'd3};
        tbl[2] = '{2'b00, 3'b010, 3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 6'd3};
        tbl[3] = '{2'b00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 6'd1};
        tbl[4] = '{2'b11, 3'b100, 3'b100, 5'd0, 5'd0, 5'd2, 2'b11, 2'b00, 1'b0, 6'd3};
        tbl[5] = '{2'b11, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 6'd0};
        tbl[6] = '{2'b11, 3'b001, 3'b000, 5'd9, 5'd0, 5'd0, 2'b11, 2'b00, 1'b0, 6'd2};
        tbl[7] = '{2'b00, 3'b111, 3'b001, 5'd2, 5'd3, 5'd2, 2'b00, 2'b00, 1'b0, 6'd2};
        tbl[8] = '{2'b00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 6'd0};
        do_reset();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        for (int v = 0; v < 9; v++) begin
            logic [4:0] di [3];
            di[0] = tbl[v].di0; di[1] = tbl[v].di1; di[2] = tbl[v].di2;
            bus.din_req = tbl[v].req;
            bus.din_npc[0] = 64'h4000 + 64'(v * 8);
            bus.din_npc[1] = 64'h4004 + 64'(v * 8);
            for (int p = 0; p < C; p++)
                if (tbl[v].dreq[p]) set_dup(p, int'(di[p]), 1'b0, 64'd0, tbl[v].dexc[p]);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", v), bus.din_gnt, tbl[v].gnt);
            chk($sformatf("tbl%0d_dval", v), bus.dout_valid, tbl[v].dval);
            chk($sformatf("tbl%0d_exc", v), bus.exception, tbl[v].exc);
            next();
            chk($sformatf("tbl%0d_cnt", v), bus.count, tbl[v].cnt);
        end
    endtask

    // ---------------- hand-written multi-cycle sequences ----------------
    task automatic run_sequences();
        // Fill to full, blocked grant, retire with count-based no-grant, refill with index wrap.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.din_req = 2'b11;
            @(negedge clk);
            chk("fill_gnt", bus.din_gnt, 2'b11);
            next();
        end
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 32);
        bus.din_req = 2'b11;
        @(negedge clk);
        chk("full_gnt", bus.din_gnt, 2'b00);
        next();
        set_dup(0, 0, 1'b0, 64'd0, 1'b0);
        set_dup(1, 1, 1'b0, 64'd0, 1'b0);
        next();
        bus.din_req = 2'b11;
        @(negedge clk);
        chk("drain_dval", bus.dout_valid, 2'b11);
        chk("drain_gnt", bus.din_gnt, 2'b00);
        next();
        chk("drain_count", bus.count, 30);
        bus.din_req = 2'b11;
        @(negedge clk);
        chk("refill_gnt", bus.din_gnt, 2'b11);
        chk("wrap_idx0", bus.rob_idx_out[0], 0);
        chk("wrap_idx1", bus.rob_idx_out[1], 1);
        next();
        chk("refill_count", bus.count, 32);

        // Mispredict in slot 0: taken resolved against not-taken prediction.
        do_reset();
        bus.din_req = 2'b11;
        bus.din_isbr = 2'b01;
        next();
        set_dup(0, 0, 1'b1, 64'h1000, 1'b0);
        set_dup(1, 1, 1'b0, 64'd0, 1'b0);
        next();
        @(negedge clk);
        chk("miss_flag", bus.branch_miss, 1);
        chk("miss_target", bus.correct_target, 64'h1000);
        chk("miss_dval", bus.dout_valid, 2'b01);
        chk("miss_brv", bus.br_out_valid, 2'b01);
        next();
        chk("miss_count", bus.count, 0);
        chk("miss_head", bus.head, 1);

        // Exception in slot 1.
        do_reset();
        bus.din_req = 2'b11;
        bus.din_npc[0] = 64'h2000;
        bus.din_npc[1] = 64'h2004;
        next();
        set_dup(0, 0, 1'b0, 64'd0, 1'b0);
        set_dup(1, 1, 1'b0, 64'd0, 1'b1);
        next();
        @(negedge clk);
        chk("exc_dval", bus.dout_valid, 2'b01);
        chk("exc_flag", bus.exception, 1);
        chk("exc_npc", bus.exc_npc, 64'h2004);
        chk("exc_retnpc", bus.dout_npc[0], 64'h2000);
        chk("exc_nomiss", bus.branch_miss, 0);
        next();
        chk("exc_empty", bus.empty, 1);
        chk("exc_count", bus.count, 0);

        // External flush.
        do_reset();
        bus.din_req = 2'b11;
        next();
        bus.din_req = 2'b11;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_gnt", bus.din_gnt, 2'b00);
        chk("flush_tgt", bus.correct_target, 0);
        next();
        chk("flush_count", bus.count, 0);

        // Asynchronous reset mid-burst.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.din_req = 2'b11;
            next();
        end
        chk("burst_count", bus.count, 10);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_empty", bus.empty, 1);
        bus.din_req = 2'b11;
        #1;
        chk("arst_gnt", bus.din_gnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        bus.din_req = 2'b11;
        @(negedge clk);
        chk("post_rst_idx0", bus.rob_idx_out[0], 0);
        chk("post_rst_gnt", bus.din_gnt, 2'b11);
        next();
    endtask

    // ---------------- randomized run against a queue model ----------------
    typedef struct {
        logic [63:0] npc;
        logic [31:0] ir;
        logic [5:0]  pdest;
        logic [4:0]  adest;
        bit          isbr;
        bit          bt_pd;
        logic [63:0] ba_pd;
        bit          ready;
        bit          exc;
        bit          bt_ex;
        logic [63:0] ba_ex;
        int          idx;
    } ment_t;

    ment_t mq[$];
    int    m_head;
    int    m_tail;

    task automatic run_random(input int ncyc);
        logic [1:0]  e_gnt, e_ret;
        bit          e_miss, e_exc, rec;
        logic [63:0] e_tgt, e_enpc;
        int          nret;
        do_reset();
        mq.delete();
        m_head = 0;
        m_tail = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            int r;
            int pc;
            r = $urandom_range(0, 2);
            bus.din_req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            for (int i = 0; i < W; i++) begin
                bus.din_npc[i]   = {$urandom, $urandom};
                bus.din_ir[i]    = $urandom;
                bus.din_pdest[i] = 6'($urandom);
                bus.din_adest[i] = 5'($urandom);
                bus.din_isbr[i]  = ($urandom_range(0, 2) == 0);
                bus.din_bt_pd[i] = 1'($urandom);
                bus.din_ba_pd[i] = ($urandom_range(0, 1) == 1) ? 64'h100 : 64'h200;
            end
            pc = (((cyc / 200) % 2) == 1) ? 15 : 55;
            for (int p = 0; p < C; p++) begin
                if ($urandom_range(0, 99) < pc) begin
                    int idx;
                    bit bt;
                    logic [63:0] ba;
                    if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                        int k;
                        k   = $urandom_range(0, mq.size() - 1);
                        idx = mq[k].idx;
                        bt  = ($urandom_range(0, 7) == 0) ? !mq[k].bt_pd : mq[k].bt_pd;
                        ba  = ($urandom_range(0, 7) == 0) ? 64'h300 : mq[k].ba_pd;
                    end else begin
                        idx = $urandom_range(0, SZ - 1);
                        bt  = 1'($urandom);
                        ba  = 64'h100;
                    end
                    set_dup(p, idx, bt, ba, ($urandom_range(0, 23) == 0));
                end
            end
            bus.flush = ($urandom_range(0, 79) == 0);

            e_ret = '0; e_miss = 0; e_exc = 0; e_tgt = '0; e_enpc = '0;
            for (int i = 0; i < W; i++) begin
                if (i >= mq.size() || !mq[i].ready) break;
                if (mq[i].exc) begin
                    e_exc = 1; e_enpc = mq[i].npc;
                    break;
                end
                e_ret[i] = 1'b1;
                if (mq[i].isbr && (mq[i].bt_ex != mq[i].bt_pd ||
                                   (mq[i].bt_ex && mq[i].ba_ex != mq[i].ba_pd))) begin
                    e_miss = 1; e_tgt = mq[i].ba_ex;
                    break;
                end
            end
            rec = e_miss || e_exc || bus.flush;
            e_gnt = '0;
            for (int i = 0; i < W; i++)
                if (bus.din_req[i] && !rec && i < SZ - mq.size()) e_gnt[i] = 1'b1;

            @(negedge clk);
            chk("rnd_count", bus.count, 64'(mq.size()));
            chk("rnd_head", bus.head, 64'(m_head % SZ));
            chk("rnd_full", bus.full, 64'(mq.size() == SZ));
            chk("rnd_empty", bus.empty, 64'(mq.size() == 0));
            chk("rnd_idx0", bus.rob_idx_out[0], 64'(m_tail % SZ));
            chk("rnd_idx1", bus.rob_idx_out[1], 64'((m_tail + 1) % SZ));
            chk("rnd_gnt", bus.din_gnt, e_gnt);
            chk("rnd_dval", bus.dout_valid, e_ret);
            chk("rnd_miss", bus.branch_miss, e_miss);
            chk("rnd_tgt", bus.correct_target, e_tgt);
            chk("rnd_exc", bus.exception, e_exc);
            chk("rnd_excnpc", bus.exc_npc, e_enpc);
            for (int i = 0; i < W; i++) begin
                if (e_ret[i]) begin
                    chk("rnd_npc", bus.dout_npc[i], mq[i].npc);
                    chk("rnd_ir", bus.dout_ir[i], 64'(mq[i].ir));
                    chk("rnd_pdest", bus.dout_pdest[i], 64'(mq[i].pdest));
                    chk("rnd_adest", bus.dout_adest[i], 64'(mq[i].adest));
                    chk("rnd_brv", bus.br_out_valid[i], 64'(mq[i].isbr));
                    if (mq[i].isbr) begin
                        chk("rnd_bt", bus.bt_out[i], 64'(mq[i].bt_ex));
                        chk("rnd_ba", bus.ba_out[i], mq[i].ba_ex);
                    end
                end
            end

            @(posedge clk);
            #1;
            nret = 0;
            for (int i = 0; i < W; i++) nret += int'(e_ret[i]);
            for (int i = 0; i < nret; i++) void'(mq.pop_front());
            m_head = (m_head + nret) % (2 * SZ);
            if (rec) begin
                mq.delete();
                m_tail = m_head;
            end else begin
                for (int p = 0; p < C; p++) begin
                    if (bus.dup_req[p]) begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (mq[k].idx == int'(bus.dup_idx[p])) begin
                                ment_t t;
                                t = mq[k];
                                t.ready = 1; t.exc = bus.dup_exc[p];
                                t.bt_ex = bus.dup_bt[p]; t.ba_ex = bus.dup_ba[p];
                                mq[k] = t;
                            end
                        end
                    end
                end
                for (int i = 0; i < W; i++) begin
                    if (e_gnt[i]) begin
                        ment_t ne;
                        ne.npc = bus.din_npc[i]; ne.ir = bus.din_ir[i];
                        ne.pdest = bus.din_pdest[i]; ne.adest = bus.din_adest[i];
                        ne.isbr = bus.din_isbr[i]; ne.bt_pd = bus.din_bt_pd[i];
                        ne.ba_pd = bus.din_ba_pd[i];
                        ne.ready = 0; ne.exc = 0; ne.bt_ex = 0; ne.ba_ex = '0;
                        ne.idx = (m_tail + i) % SZ;
                        mq.push_back(ne);
                    end
                end
                m_tail = (m_tail + int'(e_gnt[0]) + int'(e_gnt[1])) % (2 * SZ);
            end
            idle();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        run_table();
        run_sequences();
        run_random(1200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
